// File: rtl/counter_seq_ctrl.sv
// ---------------------------------------------------------------------------
// counter_seq_ctrl
//
// This block is the run-control sequencer for the 4-bit LED counter, which is
// built on REGISTER_CE. It converts debounced button levels into
// RUN/PAUSE/STEP/CLEAR/DIRECTION commands and generates a prescaled tick at a
// selectable rate. It also drives the clock-enable, synchronous clear and
// count direction of the counter register.
//
// Optional feature, selected by the macro COUNTER_SEQ_CTRL_LIMIT_EN:
//   When the macro is defined, the block counts the count_ce pulses issued in
//   RUN. After LIMIT of them, the block drops into PAUSE.
//
// Parameters:
//   CLK_FREQ    input clock frequency in Hz
//   TICK_HZ     base tick rate in Hz at rate_sel = 0
//   LIMIT       run-length limit (exists only with COUNTER_SEQ_CTRL_LIMIT_EN)
//
// Ports:
//   clk         system clock
//   rst         synchronous, active-high reset
//   btn_run     debounced level; a rising edge issues RUN
//   btn_pause   a rising edge issues PAUSE
//   btn_step    a rising edge issues a single step (only in PAUSE)
//   btn_clear   a rising edge issues CLEAR
//   btn_dir     a rising edge toggles the count direction
//   rate_sel    tick period = BASE_PERIOD >> rate_sel
//   count_ce    one-cycle enable to the counter register
//   count_clr   one-cycle synchronous clear to the counter register
//   count_up    1 = increment, 0 = decrement
//   state       00 IDLE, 01 RUN, 10 PAUSE
//   tick        one-cycle prescaler terminal pulse (debug)
// ---------------------------------------------------------------------------
module counter_seq_ctrl #(
   parameter int unsigned CLK_FREQ = 125000000,
   parameter int unsigned TICK_HZ  = 1
`ifdef COUNTER_SEQ_CTRL_LIMIT_EN
   ,
   parameter int unsigned LIMIT    = 16
`endif
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_run,
   input  logic       btn_pause,
   input  logic       btn_step,
   input  logic       btn_clear,
   input  logic       btn_dir,
   input  logic [1:0] rate_sel,
   output logic       count_ce,
   output logic       count_clr,
   output logic       count_up,
   output logic [1:0] state,
   output logic       tick
);

   localparam int unsigned BASE_PERIOD = CLK_FREQ / TICK_HZ;
   localparam int unsigned PS_W        = $clog2(BASE_PERIOD);
   // The period itself can equal 2**PS_W, so it needs one extra bit.
   localparam int unsigned P_W         = PS_W + 1;

   // At rate_sel = 3, the shifted period must stay at or above 1 cycle.
   if (BASE_PERIOD < 8) begin : g_bad_period
      $error("counter_seq_ctrl: CLK_FREQ/TICK_HZ must be >= 8");
   end

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_RUN   = 2'b01,
      ST_PAUSE = 2'b10
   } state_t;

   state_t          r_state;
   logic [PS_W-1:0] r_ps;
   logic [1:0]      r_rate_q;
   logic            r_run_q;
   logic            r_pause_q;
   logic            r_step_q;
   logic            r_clear_q;
   logic            r_dir_q;
   logic            r_ce;
   logic            r_clr;
   logic            r_up;
   logic            r_tick;

   logic            w_edge_run;
   logic            w_edge_pause;
   logic            w_edge_step;
   logic            w_edge_clear;
   logic            w_edge_dir;
   logic            w_cmd_clear;
   logic            w_cmd_pause;
   logic            w_cmd_run;
   logic            w_cmd_step;
   logic [P_W-1:0]  w_period;
   logic [PS_W-1:0] w_term_val;
   logic            w_rate_chg;
   logic            w_ps_over;
   logic            w_term;
   logic            w_step_ok;
   logic            w_limit_hit;

   // Rising-edge detection on the debounced button levels
   assign w_edge_run   = btn_run   & ~r_run_q;
   assign w_edge_pause = btn_pause & ~r_pause_q;
   assign w_edge_step  = btn_step  & ~r_step_q;
   assign w_edge_clear = btn_clear & ~r_clear_q;
   assign w_edge_dir   = btn_dir   & ~r_dir_q;

   // Only one command is accepted per cycle: clear > pause > run > step
   assign w_cmd_clear = w_edge_clear;
   assign w_cmd_pause = w_edge_pause & ~w_edge_clear;
   assign w_cmd_run   = w_edge_run   & ~w_edge_clear & ~w_edge_pause;
   assign w_cmd_step  = w_edge_step  & ~w_edge_clear & ~w_edge_pause & ~w_edge_run;

   // Prescaler period and terminal detection
   assign w_period   = P_W'(BASE_PERIOD) >> rate_sel;
   assign w_term_val = PS_W'(w_period - P_W'(1));
   assign w_rate_chg = (rate_sel != r_rate_q);
   assign w_ps_over  = ({1'b0, r_ps} >= w_period);
   // A rate change restarts the period, so that cycle can never tick
   assign w_term     = (r_state == ST_RUN) & ~w_rate_chg & (r_ps == w_term_val);
   assign w_step_ok  = (r_state == ST_PAUSE) & w_cmd_step;

`ifdef COUNTER_SEQ_CTRL_LIMIT_EN
   localparam int unsigned RC_W = $clog2(LIMIT + 1);

   logic [RC_W-1:0] r_rc;
   logic [RC_W-1:0] w_rc_next;

   assign w_rc_next   = r_rc + RC_W'(1);
   // A tick in RUN issues a count_ce unless a clear suppresses it
   assign w_limit_hit = w_term & ~w_cmd_clear & (w_rc_next == RC_W'(LIMIT));

   // Run-length counter: counts only the count_ce pulses that come from RUN ticks
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rc <= '0;
      end else if (w_cmd_clear) begin
         r_rc <= '0;
      end else if (w_term) begin
         r_rc <= w_limit_hit ? '0 : w_rc_next;
      end
   end
`else
   assign w_limit_hit = 1'b0;
`endif

   // Sequencer: FSM, prescaler, edge flops and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_ps      <= '0;
         r_rate_q  <= '0;
         r_run_q   <= 1'b0;
         r_pause_q <= 1'b0;
         r_step_q  <= 1'b0;
         r_clear_q <= 1'b0;
         r_dir_q   <= 1'b0;
         r_ce      <= 1'b0;
         r_clr     <= 1'b0;
         r_up      <= 1'b1;
         r_tick    <= 1'b0;
      end else begin
         r_run_q   <= btn_run;
         r_pause_q <= btn_pause;
         r_step_q  <= btn_step;
         r_clear_q <= btn_clear;
         r_dir_q   <= btn_dir;
         r_rate_q  <= rate_sel;

         // A clear pulse masks any coincident tick or step
         r_clr  <= w_cmd_clear;
         r_ce   <= ~w_cmd_clear & (w_term | w_step_ok);
         r_tick <= ~w_cmd_clear & w_term;

         // The counter consumes count_ce together with the current count_up
         if (w_edge_dir) begin
            r_up <= ~r_up;
         end

         // The prescaler advances only in RUN, so a pause keeps the partial period
         if (w_cmd_clear) begin
            r_ps <= '0;
         end else if (r_state == ST_RUN) begin
            if (w_rate_chg || w_ps_over || w_term) begin
               r_ps <= '0;
            end else begin
               r_ps <= r_ps + PS_W'(1);
            end
         end

         if (w_cmd_clear) begin
            r_state <= ST_IDLE;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (w_cmd_run) begin
                     r_state <= ST_RUN;
                  end
               end
               ST_RUN: begin
                  if (w_cmd_pause || w_limit_hit) begin
                     r_state <= ST_PAUSE;
                  end
               end
               ST_PAUSE: begin
                  if (w_cmd_run) begin
                     r_state <= ST_RUN;
                  end
               end
               default: begin
                  r_state <= ST_IDLE;
               end
            endcase
         end
      end
   end

   assign count_ce  = r_ce;
   assign count_clr = r_clr;
   assign count_up  = r_up;
   assign state     = r_state;
   assign tick      = r_tick;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_counter_seq_ctrl
//
// Directed testbench for counter_seq_ctrl with CLK_FREQ=16 and TICK_HZ=1,
// so BASE_PERIOD = 16 cycles. The expected values are worked out by hand
// from the command/prescaler rules.
// ---------------------------------------------------------------------------
module tb_counter_seq_ctrl;

   logic       clk;
   logic       rst;
   logic       btn_run;
   logic       btn_pause;
   logic       btn_step;
   logic       btn_clear;
   logic       btn_dir;
   logic [1:0] rate_sel;
   logic       count_ce;
   logic       count_clr;
   logic       count_up;
   logic [1:0] state;
   logic       tick;

   int n_vec;
   int n_err;
   int ce_total;
   int clr_total;

   initial clk = 1'b0;
   always #5 clk = ~clk;

`ifdef COUNTER_SEQ_CTRL_LIMIT_EN
   counter_seq_ctrl #(.CLK_FREQ(16), .TICK_HZ(1), .LIMIT(1000)) dut (
`else
   counter_seq_ctrl #(.CLK_FREQ(16), .TICK_HZ(1)) dut (
`endif
      .clk       (clk),
      .rst       (rst),
      .btn_run   (btn_run),
      .btn_pause (btn_pause),
      .btn_step  (btn_step),
      .btn_clear (btn_clear),
      .btn_dir   (btn_dir),
      .rate_sel  (rate_sel),
      .count_ce  (count_ce),
      .count_clr (count_clr),
      .count_up  (count_up),
      .state     (state),
      .tick      (tick)
   );

`ifdef COUNTER_SEQ_CTRL_LIMIT_EN
   logic       lim_ce;
   logic       lim_clr;
   logic       lim_up;
   logic [1:0] lim_state;
   logic       lim_tick;

   counter_seq_ctrl #(.CLK_FREQ(16), .TICK_HZ(1), .LIMIT(3)) dut_lim (
      .clk       (clk),
      .rst       (rst),
      .btn_run   (btn_run),
      .btn_pause (btn_pause),
      .btn_step  (btn_step),
      .btn_clear (btn_clear),
      .btn_dir   (btn_dir),
      .rate_sel  (rate_sel),
      .count_ce  (lim_ce),
      .count_clr (lim_clr),
      .count_up  (lim_up),
      .state     (lim_state),
      .tick      (lim_tick)
   );
`endif

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // Advance one cycle. Outputs are observed 1 ns after the edge and the pulses are tallied.
   task automatic step_clk();
      @(posedge clk);
      #1;
      if (count_ce)  ce_total++;
      if (count_clr) clr_total++;
   endtask

   // Run n cycles. Return the number of count_ce pulses and the index (1-based) of the first one.
   task automatic watch(input int n, output int cnt, output int first);
      cnt   = 0;
      first = 0;
      for (int i = 1; i <= n; i++) begin
         step_clk();
         if (count_ce) begin
            cnt++;
            if (first == 0) first = i;
         end
      end
   endtask

   task automatic press_run();
      btn_run = 1'b1; step_clk(); btn_run = 1'b0;
   endtask

   task automatic press_pause();
      btn_pause = 1'b1; step_clk(); btn_pause = 1'b0;
   endtask

   task automatic press_clear();
      btn_clear = 1'b1; step_clk(); btn_clear = 1'b0;
   endtask

   task automatic press_step();
      btn_step = 1'b1; step_clk(); btn_step = 1'b0;
      step_clk();
      step_clk();
   endtask

   int cnt;
   int first;
   int ce_snap;
   int clr_snap;

   initial begin
      n_vec     = 0;
      n_err     = 0;
      ce_total  = 0;
      clr_total = 0;
      rst       = 1'b1;
      btn_run   = 1'b0;
      btn_pause = 1'b0;
      btn_step  = 1'b0;
      btn_clear = 1'b0;
      btn_dir   = 1'b0;
      rate_sel  = 2'd0;

      // Reset state
      step_clk();
      step_clk();
      check_val("rst_state", 32'(state), 32'd0);
      check_val("rst_ce",    32'(count_ce), 32'd0);
      check_val("rst_clr",   32'(count_clr), 32'd0);
      check_val("rst_up",    32'(count_up), 32'd1);
      check_val("rst_tick",  32'(tick), 32'd0);
      rst = 1'b0;
      step_clk();

      // RUN at rate 0: first count_ce 16 cycles after entry, then every 16 cycles
      press_run();
      check_val("run_state", 32'(state), 32'd1);
      watch(15, cnt, first);
      check_val("run_pre_cnt", 32'(cnt), 32'd0);
      step_clk();
      check_val("run_ce16", 32'(count_ce), 32'd1);
      check_val("run_tick16", 32'(tick), 32'd1);
      step_clk();
      check_val("run_ce_1cyc", 32'(count_ce), 32'd0);
      watch(31, cnt, first);
      check_val("run_per_cnt", 32'(cnt), 32'd2);
      check_val("run_per_first", 32'(first), 32'd15);

      // Change the rate 0 -> 2 mid-period: the prescaler restarts, then the period is 4
      watch(5, cnt, first);
      check_val("rate_pre_cnt", 32'(cnt), 32'd0);
      rate_sel = 2'd2;
      watch(5, cnt, first);
      check_val("rate_first", 32'(first), 32'd5);
      check_val("rate_cnt", 32'(cnt), 32'd1);
      watch(8, cnt, first);
      check_val("rate_per_cnt", 32'(cnt), 32'd2);
      check_val("rate_per_first", 32'(first), 32'd4);

      // Pause at prescaler = 9, hold 50 cycles, resume: 6 cycles to count_ce
      rate_sel = 2'd0;
      step_clk();
      watch(9, cnt, first);
      check_val("pz_pre_cnt", 32'(cnt), 32'd0);
      press_pause();
      check_val("pz_state", 32'(state), 32'd2);
      watch(50, cnt, first);
      check_val("pz_hold_cnt", 32'(cnt), 32'd0);
      press_run();
      check_val("pz_resume_state", 32'(state), 32'd1);
      watch(6, cnt, first);
      check_val("pz_resume_first", 32'(first), 32'd6);
      check_val("pz_resume_cnt", 32'(cnt), 32'd1);

      // Steps in PAUSE: three pulses plus a 20-cycle hold give 4 count_ce
      press_pause();
      check_val("st_state", 32'(state), 32'd2);
      ce_snap = ce_total;
      press_step();
      press_step();
      press_step();
      btn_step = 1'b1;
      for (int i = 0; i < 20; i++) step_clk();
      btn_step = 1'b0;
      step_clk();
      step_clk();
      check_val("st_pause_cnt", 32'(ce_total - ce_snap), 32'd4);
      check_val("st_pause_state", 32'(state), 32'd2);

      // Steps in IDLE are ignored
      clr_snap = clr_total;
      press_clear();
      check_val("clr_idle_state", 32'(state), 32'd0);
      check_val("clr_idle_pulse", 32'(count_clr), 32'd1);
      ce_snap = ce_total;
      press_step();
      press_step();
      press_step();
      check_val("st_idle_cnt", 32'(ce_total - ce_snap), 32'd0);
      check_val("clr_idle_total", 32'(clr_total - clr_snap), 32'd1);

      // Clear, pause, run and dir edges in the same cycle while in RUN
      press_run();
      step_clk();
      step_clk();
      step_clk();
      ce_snap  = ce_total;
      clr_snap = clr_total;
      btn_clear = 1'b1;
      btn_pause = 1'b1;
      btn_run   = 1'b1;
      btn_dir   = 1'b1;
      step_clk();
      btn_clear = 1'b0;
      btn_pause = 1'b0;
      btn_run   = 1'b0;
      btn_dir   = 1'b0;
      check_val("multi_state", 32'(state), 32'd0);
      check_val("multi_clr", 32'(count_clr), 32'd1);
      check_val("multi_ce", 32'(count_ce), 32'd0);
      check_val("multi_up", 32'(count_up), 32'd0);
      step_clk();
      step_clk();
      check_val("multi_clr_total", 32'(clr_total - clr_snap), 32'd1);
      check_val("multi_ce_total", 32'(ce_total - ce_snap), 32'd0);

      // Reset mid-RUN (count_up is 0 here), then confirm the prescaler restarts from 0
      press_run();
      watch(10, cnt, first);
      check_val("mrst_pre_cnt", 32'(cnt), 32'd0);
      rst = 1'b1;
      step_clk();
      check_val("mrst_state", 32'(state), 32'd0);
      check_val("mrst_ce",    32'(count_ce), 32'd0);
      check_val("mrst_clr",   32'(count_clr), 32'd0);
      check_val("mrst_up",    32'(count_up), 32'd1);
      check_val("mrst_tick",  32'(tick), 32'd0);
      rst = 1'b0;
      step_clk();
      press_run();
      watch(16, cnt, first);
      check_val("mrst_first", 32'(first), 32'd16);

      // A dir edge toggles count_up on the next cycle
      btn_dir = 1'b1; step_clk(); btn_dir = 1'b0;
      check_val("dir_toggle", 32'(count_up), 32'd0);

`ifdef COUNTER_SEQ_CTRL_LIMIT_EN
      // With LIMIT=3 and P=4, exactly 3 count_ce pulses occur, then PAUSE
      rst = 1'b1;
      step_clk();
      rst = 1'b0;
      rate_sel = 2'd2;
      step_clk();
      step_clk();
      btn_run = 1'b1; step_clk(); btn_run = 1'b0;
      cnt = 0;
      for (int i = 0; i < 30; i++) begin
         step_clk();
         if (lim_ce) cnt++;
      end
      check_val("lim_cnt", 32'(cnt), 32'd3);
      check_val("lim_state", 32'(lim_state), 32'd2);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
